// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler
//   Traffic-light phase scheduler for a highway / country-road crossing
//   with a pedestrian walk phase and an emergency preempt toward the
//   highway. Moore FSM: HG -> HY -> AR -> {HG, CG, PW}, CG -> CY -> AR,
//   PW -> AR. Every road change passes through yellow and all-red.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (forces HG)
//   Xh, Xc     highway / country vehicle present
//   Pb         pedestrian button (level or pulse), latched into ped_pend
//   Ev         emergency preempt toward the highway
//   Gh,Yh,Rh   highway lamps
//   Gc,Yc,Rc   country lamps
//   walk,
//   dont_walk  pedestrian lamps (dont_walk is always ~walk)
//   ped_ack    one-cycle pulse on the first cycle of PW
//   phase      current state: HG=0 HY=1 AR=2 CG=3 CY=4 PW=5
module tlc_phase_scheduler #(
  parameter int T_MIN_H = 8,
  parameter int T_MIN_C = 4,
  parameter int T_MAX_C = 12,
  parameter int T_Y     = 3,
  parameter int T_AR    = 2,
  parameter int T_WALK  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Xh,
  input  logic       Xc,
  input  logic       Pb,
  input  logic       Ev,
  output logic       Gh,
  output logic       Yh,
  output logic       Rh,
  output logic       Gc,
  output logic       Yc,
  output logic       Rc,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HG = 3'd0, HY = 3'd1, AR = 3'd2, CG = 3'd3, CY = 3'd4, PW = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HWY = 2'd0, CTRY = 2'd1, PED = 2'd2
  } tgt_t;

  // Timer is wide enough to hold the longest dwell; it saturates at all-ones.
  localparam int M1   = (T_MIN_H > T_MAX_C) ? T_MIN_H : T_MAX_C;
  localparam int M2   = (M1 > T_WALK) ? M1 : T_WALK;
  localparam int M3   = (M2 > T_Y) ? M2 : T_Y;
  localparam int M4   = (M3 > T_AR) ? M3 : T_AR;
  localparam int TMAX = (M4 > T_MIN_C) ? M4 : T_MIN_C;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TMR_SAT   = '1;
  // tmr counts from 0 on state entry, so a dwell of T ends when tmr == T-1.
  localparam logic [TW-1:0] H_LAST    = TW'(T_MIN_H - 1);
  localparam logic [TW-1:0] CMIN_LAST = TW'(T_MIN_C - 1);
  localparam logic [TW-1:0] CMAX_LAST = TW'(T_MAX_C - 1);
  localparam logic [TW-1:0] Y_LAST    = TW'(T_Y - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(T_AR - 1);
  localparam logic [TW-1:0] W_LAST    = TW'(T_WALK - 1);

  state_t        state;
  state_t        state_next;
  tgt_t          tgt;
  tgt_t          tgt_next;
  logic [TW-1:0] tmr;
  logic          ped_pend;

  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    case (state)
      HG: begin
        // Ev pins the highway green; pedestrians win over a waiting car.
        if (!Ev && (tmr >= H_LAST) && (Xc || ped_pend)) begin
          state_next = HY;
          tgt_next   = ped_pend ? PED : CTRY;
        end
      end
      HY, CY: begin
        // Preempt only retargets; yellow is never cut short.
        if (Ev) tgt_next = HWY;
        if (tmr >= Y_LAST) state_next = AR;
      end
      AR: begin
        if (Ev) tgt_next = HWY;
        if (tmr >= AR_LAST) begin
          if (Ev) begin
            state_next = HG;
          end else begin
            case (tgt)
              CTRY:    state_next = CG;
              PED:     state_next = PW;
              default: state_next = HG;
            endcase
          end
        end
      end
      CG: begin
        if (Ev || (tmr >= CMAX_LAST) ||
            ((tmr >= CMIN_LAST) && (!Xc || Xh || ped_pend))) begin
          state_next = CY;
          tgt_next   = (ped_pend && !Ev) ? PED : HWY;
        end
      end
      PW: begin
        if (Ev || (tmr >= W_LAST)) begin
          state_next = AR;
          tgt_next   = HWY;
        end
      end
      default: begin
        state_next = HG;
        tgt_next   = HWY;
      end
    endcase
  end

  // Lamps are registered from the next state so they line up with state
  // and come straight out of flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HG;
      tgt       <= HWY;
      tmr       <= '0;
      ped_pend  <= 1'b0;
      ped_ack   <= 1'b0;
      Gh        <= 1'b1;
      Yh        <= 1'b0;
      Rh        <= 1'b0;
      Gc        <= 1'b0;
      Yc        <= 1'b0;
      Rc        <= 1'b1;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      phase     <= 3'd0;
    end else begin
      state <= state_next;
      tgt   <= tgt_next;

      if (state_next != state) tmr <= '0;
      else if (tmr != TMR_SAT) tmr <= tmr + TW'(1);

      // Entering PW serves the request; presses during PW are dropped.
      if (state_next == PW && state != PW) ped_pend <= 1'b0;
      else if (Pb && state != PW)          ped_pend <= 1'b1;

      ped_ack   <= (state_next == PW) && (state != PW);
      Gh        <= (state_next == HG);
      Yh        <= (state_next == HY);
      Rh        <= (state_next inside {AR, CG, CY, PW});
      Gc        <= (state_next == CG);
      Yc        <= (state_next == CY);
      Rc        <= (state_next inside {HG, HY, AR, PW});
      walk      <= (state_next == PW);
      dont_walk <= (state_next != PW);
      phase     <= state_next;
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: phase sequences and dwell lengths,
// pedestrian service and acknowledge, emergency preempt, asynchronous reset,
// plus a random-input stretch watched by a lamp-safety monitor.
module tb_tlc_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Xh = 1'b0, Xc = 1'b0, Pb = 1'b0, Ev = 1'b0;
  logic       Gh, Yh, Rh, Gc, Yc, Rc, walk, dont_walk, ped_ack;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  localparam int P_HG = 0, P_HY = 1, P_AR = 2, P_CG = 3, P_CY = 4, P_PW = 5;
  localparam logic [14:0] RST_V = {8'b1000_0101, 1'b0, 3'd0};

  logic [14:0] outv;
  logic [7:0]  lamps;
  assign lamps = {Gh, Yh, Rh, Gc, Yc, Rc, walk, dont_walk};
  assign outv  = {lamps, ped_ack, phase};

  tlc_phase_scheduler dut (
    .clk(clk), .reset(reset),
    .Xh(Xh), .Xc(Xc), .Pb(Pb), .Ev(Ev),
    .Gh(Gh), .Yh(Yh), .Rh(Rh), .Gc(Gc), .Yc(Yc), .Rc(Rc),
    .walk(walk), .dont_walk(dont_walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Expected {Gh,Yh,Rh,Gc,Yc,Rc,walk,dont_walk} for each phase.
  function automatic logic [7:0] lamp_tab(input int ph);
    case (ph)
      P_HG:    return 8'b1000_0101;
      P_HY:    return 8'b0100_0101;
      P_AR:    return 8'b0010_0101;
      P_CG:    return 8'b0011_0001;
      P_CY:    return 8'b0010_1001;
      P_PW:    return 8'b0010_0110;
      default: return 8'hFF;
    endcase
  endfunction

  // Lamp-safety monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (((Gh | Yh) & (Gc | Yc)) ||
          (walk & (Gh | Yh | Gc | Yc)) ||
          ((int'(Gh) + int'(Yh) + int'(Rh)) != 1) ||
          ((int'(Gc) + int'(Yc) + int'(Rc)) != 1) ||
          (dont_walk == walk))
        viol <= viol + 1;
    end
  end

  // Async reset assert mid-cycle, hold two edges, release at a negedge.
  // On return the current cycle is HG cycle 1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check({tag, "_async"}, int'(outv), int'(RST_V));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_held"}, int'(outv), int'(RST_V));
    reset = 1'b1;
  endtask

  // Current cycle is number 'first' of phase ph; count until the phase
  // changes and compare the total dwell. Returns on cycle 1 of the next phase.
  task automatic run_phase(input string tag, input int ph, input int first, input int exp_len);
    int n;
    bit done;
    check({tag, "_ph"}, int'(phase), ph);
    check({tag, "_lamp"}, int'(lamps), int'(lamp_tab(ph)));
    n = first;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (int'(phase) != ph) done = 1'b1;
      else n++;
    end
    check({tag, "_len"}, n, exp_len);
  endtask

  task automatic pb_pulse_at_c2();
    @(negedge clk); Pb = 1'b1;
    @(negedge clk); Pb = 1'b0;
  endtask

  initial begin
    // Car waiting from reset: full country cycle at maximum green.
    Xc = 1'b1;
    do_reset("t1_rst");
    run_phase("t1_hg", P_HG, 1, 8);
    run_phase("t1_hy", P_HY, 1, 3);
    run_phase("t1_ar", P_AR, 1, 2);
    run_phase("t1_cg", P_CG, 1, 12);
    run_phase("t1_cy", P_CY, 1, 3);
    run_phase("t1_ar2", P_AR, 1, 2);
    check("t1_back", int'(phase), P_HG);
    Xc = 1'b0;

    // Pedestrian pulse at HG cycle 2; press during PW is ignored.
    do_reset("t2_rst");
    pb_pulse_at_c2();
    run_phase("t2_hg", P_HG, 3, 8);
    run_phase("t2_hy", P_HY, 1, 3);
    run_phase("t2_ar", P_AR, 1, 2);
    check("t2_ack1", int'(ped_ack), 1);
    @(negedge clk); Pb = 1'b1;
    check("t2_ack2", int'(ped_ack), 0);
    @(negedge clk); Pb = 1'b0;
    run_phase("t2_pw", P_PW, 3, 6);
    run_phase("t2_ar2", P_AR, 1, 2);
    check("t2_back", int'(phase), P_HG);
    repeat (12) @(negedge clk);
    check("t2_hold", int'(phase), P_HG);

    // Car arrives at HG cycle 9, leaves during CG: CY after CG cycle 5.
    do_reset("t3_rst");
    repeat (8) @(negedge clk);
    Xc = 1'b1;
    run_phase("t3_hg", P_HG, 9, 9);
    run_phase("t3_hy", P_HY, 1, 3);
    run_phase("t3_ar", P_AR, 1, 2);
    check("t3_cg1", int'(phase), P_CG);
    repeat (4) @(negedge clk);
    Xc = 1'b0;
    run_phase("t3_cg", P_CG, 5, 5);
    run_phase("t3_cy", P_CY, 1, 3);
    run_phase("t3_ar2", P_AR, 1, 2);
    check("t3_back", int'(phase), P_HG);

    // Emergency at CG cycle 1, then HG held while Ev stays high.
    Xc = 1'b1;
    do_reset("t4_rst");
    run_phase("t4_hg", P_HG, 1, 8);
    run_phase("t4_hy", P_HY, 1, 3);
    run_phase("t4_ar", P_AR, 1, 2);
    Ev = 1'b1;
    run_phase("t4_cg", P_CG, 1, 1);
    run_phase("t4_cy", P_CY, 1, 3);
    run_phase("t4_ar2", P_AR, 1, 2);
    check("t4_back", int'(phase), P_HG);
    repeat (20) @(negedge clk);
    check("t4_hold", int'(phase), P_HG);
    Ev = 1'b0;
    @(negedge clk);
    check("t4_release", int'(phase), P_HY);
    Xc = 1'b0;

    // Car and pedestrian together: walk first, country on the next exit.
    Xc = 1'b1;
    do_reset("t5_rst");
    pb_pulse_at_c2();
    run_phase("t5_hg", P_HG, 3, 8);
    run_phase("t5_hy", P_HY, 1, 3);
    run_phase("t5_ar", P_AR, 1, 2);
    run_phase("t5_pw", P_PW, 1, 6);
    run_phase("t5_ar2", P_AR, 1, 2);
    run_phase("t5_hg2", P_HG, 1, 8);
    run_phase("t5_hy2", P_HY, 1, 3);
    run_phase("t5_ar3", P_AR, 1, 2);
    check("t5_cg", int'(phase), P_CG);
    Xc = 1'b0;

    // Asynchronous reset in the middle of PW.
    do_reset("t6_rst");
    pb_pulse_at_c2();
    run_phase("t6_hg", P_HG, 3, 8);
    run_phase("t6_hy", P_HY, 1, 3);
    run_phase("t6_ar", P_AR, 1, 2);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_pw", int'(phase), P_PW);
    #2 reset = 1'b0;
    #1 check("t6_async", int'(outv), int'(RST_V));
    @(negedge clk); reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_hold", int'(phase), P_HG);

    // Reset mid-yellow with a pedestrian press pending: the press is lost.
    Xc = 1'b1;
    do_reset("t6b_rst");
    run_phase("t6b_hg", P_HG, 1, 8);
    Pb = 1'b1;
    @(negedge clk); Pb = 1'b0;
    check("t6b_in_hy", int'(phase), P_HY);
    #2 reset = 1'b0;
    #1 check("t6b_async", int'(outv), int'(RST_V));
    Xc = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t6b_hold", int'(phase), P_HG);

    // Emergency during PW ends the walk at once.
    do_reset("t7_rst");
    pb_pulse_at_c2();
    run_phase("t7_hg", P_HG, 3, 8);
    run_phase("t7_hy", P_HY, 1, 3);
    run_phase("t7_ar", P_AR, 1, 2);
    check("t7_pw1", int'(phase), P_PW);
    @(negedge clk); Ev = 1'b1;
    @(negedge clk); Ev = 1'b0;
    run_phase("t7_ar2", P_AR, 1, 2);
    check("t7_back", int'(phase), P_HG);

    // Random inputs under the safety monitor.
    do_reset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Xh = 1'($urandom_range(0, 1));
      Xc = 1'($urandom_range(0, 1));
      Pb = ($urandom_range(0, 7) == 0);
      Ev = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    check("safety", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 SHALL provide parameter T_MIN_H, default 8: minimum highway-green cycles.
REQ-002 SHALL provide parameter T_MIN_C, default 4: minimum country-green cycles.
REQ-003 SHALL provide parameter T_MAX_C, default 12: maximum country-green cycles.
REQ-004 SHALL provide parameter T_Y, default 3: yellow cycles. Parameter T_AR, default 2: all-red cycles. Parameter T_WALK, default 6: pedestrian-walk cycles.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL provide inputs Xh, Xc, Pb and Ev, each 1 bit. Xh is highway traffic present. Xc is country car present. Pb is the pedestrian button, level or pulse. Ev is emergency preempt toward highway.
REQ-008 SHALL provide outputs Gh, Yh, Rh, Gc, Yc and Rc, each 1 bit: the lamp drives.
REQ-009 SHALL provide outputs walk and dont_walk, each 1 bit: pedestrian lamps.
REQ-010 SHALL provide output ped_ack, 1 bit: one-cycle acknowledge pulse.
REQ-011 SHALL provide output phase, 3 bits. Encoding: HG=0, HY=1, AR=2, CG=3, CY=4, PW=5.

Function
REQ-012 SHALL be a Moore FSM with states HG, HY, AR, CG, CY and PW, plus dwell timer tmr, pedestrian latch ped_pend and 2-bit target register tgt ∈ {HWY, CTRY, PED}.
REQ-013 SHALL clear tmr to 0 on every state change; otherwise tmr SHALL increment each cycle and saturate at max. "Dwell T" SHALL mean exactly T cycles in the state.
REQ-014 SHALL decode lamps from the state only:
- HG: Gh, Rc
- HY: Yh, Rc
- AR: Rh, Rc
- CG: Rh, Gc
- CY: Rh, Yc
- PW: Rh, Rc, walk
All other lamp outputs SHALL be 0. dont_walk SHALL equal the inverse of walk.
REQ-015 SHALL set ped_pend on any cycle with Pb=1 in a state other than PW. ped_pend SHALL clear on PW entry. Pb while in PW SHALL be ignored.
REQ-016 HG SHALL go to HY when tmr ≥ T_MIN_H−1, Ev=0, and (Xc=1 or ped_pend=1). tgt SHALL be set to PED if ped_pend, else CTRY.
REQ-017 While Ev=1, HG SHALL hold regardless of the timer or any request.
REQ-018 HY SHALL go to AR after T_Y dwell. CY SHALL go to AR after T_Y dwell.
REQ-019 AR SHALL exit after T_AR dwell to the state selected by tgt: HWY→HG, CTRY→CG, PED→PW. If Ev=1 on the exit cycle, AR SHALL go to HG.
REQ-020 CG SHALL go to CY when any of the following holds:
- tmr ≥ T_MAX_C−1
- tmr ≥ T_MIN_C−1 and (Xc=0 or Xh=1 or ped_pend=1)
- Ev=1, immediately, ignoring the minimum
tgt SHALL be set to PED if ped_pend=1 and Ev=0, else HWY.
REQ-021 PW SHALL go to AR after T_WALK dwell with tgt=HWY.
REQ-022 Ev=1 in PW SHALL end PW immediately: next state AR, tgt=HWY.
REQ-023 ped_ack SHALL be 1 for exactly the first cycle of PW.
REQ-024 Ev=1 during HY, CY or AR SHALL force tgt=HWY. Yellow and all-red dwells SHALL never be shortened.
REQ-025 The FSM SHALL never drive green on both roads, and SHALL never go green→red without yellow. A vehicle green SHALL never be adjacent to PW without an intervening AR.
REQ-026 Simultaneous Xc and ped_pend at HG exit SHALL serve pedestrian first. Country SHALL then be served on a later HG exit if Xc persists.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force state=HG, tmr=0, ped_pend=0 and tgt=HWY.
REQ-028 Outputs during and after reset SHALL be Gh=1, Rc=1, dont_walk=1, and every other output 0, with phase=0.
REQ-029 Reset asserted mid-phase, including in PW or yellow, SHALL abort immediately to HG. The first HG after reset SHALL enforce the full T_MIN_H.

Verification
REQ-030 Xc=1 held from reset release SHALL give phases: HG 8 cycles, HY 3, AR 2, CG 12 (max), CY 3, AR 2, HG.
REQ-031 A 1-cycle Pb pulse at HG cycle 2, with Xc=0, SHALL give HG to cycle 8, then HY 3, AR 2, PW 6 with ped_ack on the first PW cycle, then AR 2, HG.
REQ-032 Xc=1 at HG cycle 9, dropped 5 cycles into CG, SHALL give CY right after CG cycle 5, at the minimum-satisfied check.
REQ-033 Ev=1 asserted at CG cycle 1 SHALL give CY on the next cycle, full 3-cycle yellow, AR 2, then HG. HG SHALL then hold while Ev=1 even with Xc=1.
REQ-034 reset=0 pulsed asynchronously mid-PW SHALL give outputs at their reset values without a clock edge, and ped_pend=0.
REQ-035 Across all random stimulus, a checker SHALL confirm these never occur: (Gh or Yh) with (Gc or Yc); walk with any green or yellow; more than one lamp per road.
